sys_bus_xbar: RTL and testbench

- Parametrised single-master to N-slave bus decoder and read-response mux with a ready handshake, wait-state support and timeout/decode-error reporting.
- Sits between the CPU's memory-stage data port (registered address, write data, byte enables, write strobe) and the data-side slaves: data RAM, tbman, timer, GPIO, UART.
- Generalises the fixed two-slave decoder and combinational read mux to NSLAVE configurable address windows.
- Unlike the fixed version, slaves may stall, and unmapped or hung accesses terminate with an error response.

---
 rtl/sys_bus_xbar.sv | 216 +++++++++++++++++++++
 tb/tb_sys_bus_xbar.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_xbar.sv
// sys_bus_xbar: single-master to NSLAVE-slave bus decoder and read-response mux.
// Each access is routed to one slave window, may be stretched by slave wait
// states, and ends with exactly one m_ready strobe. An unmapped address ends
// with an error response, and so does a slave that never answers.
module sys_bus_xbar #(
  parameter int NSLAVE = 4,
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [NSLAVE*AWIDTH-1:0] BASE_LIST =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [NSLAVE*AWIDTH-1:0] MASK_LIST = {NSLAVE{32'hF000_0000}},
  parameter int TIMEOUT = 15,
  parameter logic [DWIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [AWIDTH-1:0]        m_addr,
  input  logic [DWIDTH-1:0]        m_wdata,
  input  logic [DWIDTH/8-1:0]      m_be,
  output logic                     m_ready,
  output logic                     m_err,
  output logic [DWIDTH-1:0]        m_rdata,
  output logic [NSLAVE-1:0]        s_sel,
  output logic                     s_we,
  output logic [AWIDTH-1:0]        s_addr,
  output logic [DWIDTH-1:0]        s_wdata,
  output logic [DWIDTH/8-1:0]      s_be,
  input  logic [NSLAVE-1:0]        s_ready,
  input  logic [NSLAVE*DWIDTH-1:0] s_rdata
);

  localparam int BW = DWIDTH / 8;
  localparam int IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NSLAVE-1:0] s_sel_q, s_sel_d;
  logic              s_we_q, s_we_d;
  logic [AWIDTH-1:0] s_addr_q, s_addr_d;
  logic [DWIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [BW-1:0]     s_be_q, s_be_d;
  logic              m_ready_q, m_ready_d;
  logic              m_err_q, m_err_d;
  logic [DWIDTH-1:0] m_rdata_q, m_rdata_d;

  logic              hit;
  logic [IW-1:0]     hit_idx;
  logic              sel_ready;
  logic [DWIDTH-1:0] sel_rdata;
  logic              timeout_hit;

  // Address decode: scan from the top index down so the lowest matching window wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((m_addr & MASK_LIST[i*AWIDTH +: AWIDTH]) ==
          (BASE_LIST[i*AWIDTH +: AWIDTH] & MASK_LIST[i*AWIDTH +: AWIDTH])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Pick the ready and read data of the latched slave only; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a hit goes to ACCESS, a miss straight to RESP; ACCESS ends on ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          state_d = hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (sel_ready || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: compute next values of the registered slave-side and master-side outputs.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    m_ready_d = 1'b0;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        m_err_d = 1'b0;
        if (m_req) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_be_d    = m_be;
          idx_d     = hit_idx;
          if (hit) begin
            for (int i = 0; i < NSLAVE; i++) begin
              s_sel_d[i] = (hit_idx == IW'(i));
            end
            s_we_d = m_we;
          end else begin
            s_sel_d   = '0;
            s_we_d    = 1'b0;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = s_we_q ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        cnt_d   = '0;
        m_err_d = 1'b0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers; reset drops any in-flight select without responding.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_be    = s_be_q;

endmodule

// File: tb/tb_sys_bus_xbar.sv
// tb_sys_bus_xbar: directed bench for sys_bus_xbar. Slave 1's window is
// widened so that address 0x1000_0004 falls in both slave 0 and slave 1.
module tb_sys_bus_xbar;

  localparam int NSLAVE = 4;
  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;
  localparam int BW     = DWIDTH / 8;

  // Slave 1 matches any address with bits 31:30 = 00 and low 28 bits = 0x000_0004.
  localparam logic [NSLAVE*AWIDTH-1:0] BASE =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0004, 32'h1000_0000};
  localparam logic [NSLAVE*AWIDTH-1:0] MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hCFFF_FFFF, 32'hF000_0000};

  logic                     clk = 1'b0;
  logic                     n_rst = 1'b0;
  logic                     m_req = 1'b0;
  logic                     m_we = 1'b0;
  logic [AWIDTH-1:0]        m_addr = '0;
  logic [DWIDTH-1:0]        m_wdata = '0;
  logic [BW-1:0]            m_be = '0;
  logic                     m_ready;
  logic                     m_err;
  logic [DWIDTH-1:0]        m_rdata;
  logic [NSLAVE-1:0]        s_sel;
  logic                     s_we;
  logic [AWIDTH-1:0]        s_addr;
  logic [DWIDTH-1:0]        s_wdata;
  logic [BW-1:0]            s_be;
  logic [NSLAVE-1:0]        s_ready = '0;
  logic [NSLAVE*DWIDTH-1:0] s_rdata =
    {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};

  int vectors = 0;
  int miscompares = 0;

  sys_bus_xbar #(
    .NSLAVE   (NSLAVE),
    .AWIDTH   (AWIDTH),
    .DWIDTH   (DWIDTH),
    .BASE_LIST(BASE),
    .MASK_LIST(MASK),
    .TIMEOUT  (15),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_be   (m_be),
    .m_ready(m_ready),
    .m_err  (m_err),
    .m_rdata(m_rdata),
    .s_sel  (s_sel),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_be   (s_be),
    .s_ready(s_ready),
    .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    m_req   = req;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_be    = be;
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rst_m_ready", 32'(m_ready), 32'h0);
    checkOutput("rst_m_err",   32'(m_err),   32'h0);
    checkOutput("rst_s_sel",   32'(s_sel),   32'h0);
    checkOutput("rst_s_we",    32'(s_we),    32'h0);
    checkOutput("rst_m_rdata", m_rdata,      32'h0);
    checkOutput("rst_s_addr",  s_addr,       32'h0);
    #6;
    n_rst = 1'b1;
    tick();

    // Zero-wait read to slave 0
    applyStimulus(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    tick();
    checkOutput("zw_s_sel",  32'(s_sel), 32'h1);
    checkOutput("zw_s_we",   32'(s_we),  32'h0);
    checkOutput("zw_s_addr", s_addr,     32'h1000_0010);
    checkOutput("zw_ready1", 32'(m_ready), 32'h0);
    s_ready = 4'b0001;
    s_rdata[0 +: 32] = 32'h1234_5678;
    tick();
    checkOutput("zw_m_ready", 32'(m_ready), 32'h1);
    checkOutput("zw_m_err",   32'(m_err),   32'h0);
    checkOutput("zw_m_rdata", m_rdata,      32'h1234_5678);
    checkOutput("zw_sel_off", 32'(s_sel),   32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();
    checkOutput("zw_one_pulse", 32'(m_ready), 32'h0);

    // Write to slave 1 with three wait states; slave 0's ready must be ignored
    applyStimulus(1'b1, 1'b1, 32'h2000_0004, 32'hA5A5_5A5A, 4'b0011);
    tick();
    checkOutput("ws_s_sel",   32'(s_sel), 32'h2);
    checkOutput("ws_s_we",    32'(s_we),  32'h1);
    checkOutput("ws_s_be",    32'(s_be),  32'h3);
    checkOutput("ws_s_wdata", s_wdata,    32'hA5A5_5A5A);
    s_ready = 4'b0001;
    m_addr  = 32'h4000_0000;
    m_wdata = 32'h0;
    tick();
    checkOutput("ws_sel_c2", 32'(s_sel), 32'h2);
    tick();
    checkOutput("ws_sel_c3",  32'(s_sel), 32'h2);
    checkOutput("ws_addr_c3", s_addr,     32'h2000_0004);
    tick();
    checkOutput("ws_sel_c4",   32'(s_sel),   32'h2);
    checkOutput("ws_we_c4",    32'(s_we),    32'h1);
    checkOutput("ws_ready_c4", 32'(m_ready), 32'h0);
    s_ready = 4'b0010;
    tick();
    checkOutput("ws_m_ready", 32'(m_ready), 32'h1);
    checkOutput("ws_m_err",   32'(m_err),   32'h0);
    checkOutput("ws_m_rdata", m_rdata,      32'h0);
    checkOutput("ws_we_off",  32'(s_we),    32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();

    // Decode miss
    applyStimulus(1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'hF);
    tick();
    checkOutput("miss_m_ready", 32'(m_ready), 32'h1);
    checkOutput("miss_m_err",   32'(m_err),   32'h1);
    checkOutput("miss_m_rdata", m_rdata,      32'hDEAD_BEEF);
    checkOutput("miss_s_sel",   32'(s_sel),   32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    // Timeout: slave 2 never readies, every other slave does
    applyStimulus(1'b1, 1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick();
    checkOutput("to_s_sel", 32'(s_sel), 32'h4);
    s_ready = 4'b1011;
    for (int c = 2; c <= 16; c++) tick();
    checkOutput("to_sel_c16",   32'(s_sel),   32'h4);
    checkOutput("to_ready_c16", 32'(m_ready), 32'h0);
    tick();
    checkOutput("to_m_ready", 32'(m_ready), 32'h1);
    checkOutput("to_m_err",   32'(m_err),   32'h1);
    checkOutput("to_m_rdata", m_rdata,      32'hDEAD_BEEF);
    checkOutput("to_sel_off", 32'(s_sel),   32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();

    // Slave 2 readies exactly on the timeout cycle: ready wins
    applyStimulus(1'b1, 1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick();
    for (int c = 2; c <= 16; c++) tick();
    checkOutput("tr_ready_c16", 32'(m_ready), 32'h0);
    s_ready = 4'b0100;
    s_rdata[64 +: 32] = 32'hCAFE_F00D;
    tick();
    checkOutput("tr_m_ready", 32'(m_ready), 32'h1);
    checkOutput("tr_m_err",   32'(m_err),   32'h0);
    checkOutput("tr_m_rdata", m_rdata,      32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();

    // Back-to-back reads to slave 3 then the overlapping address (slave 0 wins)
    applyStimulus(1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'hF);
    tick();
    checkOutput("bb_sel_a", 32'(s_sel), 32'h8);
    s_ready = 4'b1000;
    s_rdata[96 +: 32] = 32'h3333_3333;
    tick();
    checkOutput("bb_ready_a", 32'(m_ready), 32'h1);
    checkOutput("bb_rdata_a", m_rdata,      32'h3333_3333);
    m_addr  = 32'h1000_0004;
    s_ready = 4'b0000;
    tick();
    checkOutput("bb_gap", 32'(m_ready), 32'h0);
    tick();
    checkOutput("bb_sel_b",  32'(s_sel), 32'h1);
    checkOutput("bb_addr_b", s_addr,     32'h1000_0004);
    s_ready = 4'b0011;
    s_rdata[0 +: 32]  = 32'h0000_1111;
    s_rdata[32 +: 32] = 32'h0000_2222;
    tick();
    checkOutput("bb_ready_b", 32'(m_ready), 32'h1);
    checkOutput("bb_rdata_b", m_rdata,      32'h0000_1111);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();

    // Reset taken in the middle of a write access
    applyStimulus(1'b1, 1'b1, 32'h1000_0040, 32'h5555_AAAA, 4'hF);
    tick();
    checkOutput("rm_sel_pre", 32'(s_sel), 32'h1);
    checkOutput("rm_we_pre",  32'(s_we),  32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("rm_sel_async",   32'(s_sel),   32'h0);
    checkOutput("rm_we_async",    32'(s_we),    32'h0);
    checkOutput("rm_ready_async", 32'(m_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0001;
    #3;
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rm_no_ready", 32'(m_ready), 32'h0);
      checkOutput("rm_no_sel",   32'(s_sel),   32'h0);
    end
    s_ready = 4'b0000;

    // Block is back in IDLE and serves a fresh read to slave 2
    applyStimulus(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    checkOutput("post_sel", 32'(s_sel), 32'h4);
    s_ready = 4'b0100;
    s_rdata[64 +: 32] = 32'h0BAD_F00D;
    tick();
    checkOutput("post_ready", 32'(m_ready), 32'h1);
    checkOutput("post_rdata", m_rdata,      32'h0BAD_F00D);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
